// File: rtl/btn_cmd_pkg.sv
// Shared types and defaults for the push-button command front end.
package btn_cmd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } cmd_state_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchronizer, persistence-counter debounce,
// debounced level and a registered one-cycle press pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_async,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             s1;
    logic             s2;
    logic             stable;
    logic             stable_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // Count how long the synchronized level has disagreed with the accepted one;
    // accept it once it has persisted for DEBOUNCE_CYCLES samples.
    always_comb begin
        stable_next = stable;
        cnt_next    = '0;
        if (s2 != stable) begin
            if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_next = s2;
            end else begin
                cnt_next = cnt + CNT_W'(1);
            end
        end
    end

    // Synchronizer, debounce state and press pulse registers. The press pulse is
    // registered so the pending logic downstream is fed from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            s1     <= btn_async;
            s2     <= s1;
            stable <= stable_next;
            cnt    <= cnt_next;
            press  <= stable_next & ~stable;
        end
    end

    assign level = stable;

endmodule

// File: rtl/btn_cmd_ctrl.sv
// Button front end: per-button debounce, pending/overrun bookkeeping,
// round-robin arbitration and a valid/ready command offer to the game FSM.
module btn_cmd_ctrl
    import btn_cmd_pkg::*;
#(
    parameter int  NUM_BTN         = 4,
    parameter int  DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    localparam int ID_W            = $clog2(NUM_BTN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_async,
    output logic               cmd_valid,
    output logic [ID_W-1:0]    cmd_id,
    input  logic               cmd_ready,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] overrun,
    input  logic [NUM_BTN-1:0] ovr_clr
);

    cmd_state_t         state;
    cmd_state_t         state_next;
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] pending;
    logic [NUM_BTN-1:0] pending_cleared;
    logic [NUM_BTN-1:0] pending_next;
    logic [NUM_BTN-1:0] overrun_next;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    rr_ptr_next;
    logic [ID_W-1:0]    grant;
    logic [ID_W-1:0]    grant_hi;
    logic [ID_W-1:0]    grant_lo;
    logic               grant_hi_vld;
    logic               grant_vld;
    logic               do_grant;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk),
            .rst      (rst),
            .btn_async(btn_async[i]),
            .level    (btn_level[i]),
            .press    (press[i])
        );
    end

    // Round-robin pick: lowest pending index at or above rr_ptr, otherwise
    // wrap to the lowest pending index overall.
    always_comb begin
        grant_hi     = '0;
        grant_lo     = '0;
        grant_hi_vld = 1'b0;
        grant_vld    = 1'b0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pending[i]) begin
                grant_vld = 1'b1;
                grant_lo  = ID_W'(i);
                if (ID_W'(i) >= rr_ptr) begin
                    grant_hi_vld = 1'b1;
                    grant_hi     = ID_W'(i);
                end
            end
        end
        grant       = grant_hi_vld ? grant_hi : grant_lo;
        rr_ptr_next = (grant == ID_W'(NUM_BTN - 1)) ? '0 : grant + ID_W'(1);
    end

    // Offer FSM next state: grant from IDLE, hold in OFFER until accepted.
    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    do_grant   = 1'b1;
                    state_next = OFFER;
                end
            end
            OFFER: begin
                if (cmd_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pending/overrun update; a new press beats the grant clear, and a press is
    // only lost (overrun) if the bit stays pending after this edge's grant.
    always_comb begin
        pending_cleared = pending;
        if (do_grant) begin
            pending_cleared[grant] = 1'b0;
        end
        pending_next = pending_cleared | press;
        overrun_next = (overrun & ~ovr_clr) | (press & pending_cleared);
    end

    // State, bookkeeping and command output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            overrun   <= '0;
            rr_ptr    <= '0;
            cmd_valid <= 1'b0;
            cmd_id    <= '0;
        end else begin
            state     <= state_next;
            pending   <= pending_next;
            overrun   <= overrun_next;
            cmd_valid <= (state_next == OFFER);
            if (do_grant) begin
                cmd_id <= grant;
                rr_ptr <= rr_ptr_next;
            end
        end
    end

endmodule
